// File: rtl/friscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// One access is in flight at a time; the owner's bus passes straight through to memory.
module friscv_mem_arbiter #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic              p0_en,
  input  logic              p0_wr,
  input  logic [ADDRW-1:0]  p0_addr,
  input  logic [XLEN-1:0]   p0_wdata,
  input  logic [XLEN/8-1:0] p0_strb,
  output logic [XLEN-1:0]   p0_rdata,
  output logic              p0_ready,
  input  logic              p1_en,
  input  logic              p1_wr,
  input  logic [ADDRW-1:0]  p1_addr,
  input  logic [XLEN-1:0]   p1_wdata,
  input  logic [XLEN/8-1:0] p1_strb,
  output logic [XLEN-1:0]   p1_rdata,
  output logic              p1_ready,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDRW-1:0]  m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_strb,
  input  logic [XLEN-1:0]   m_rdata,
  input  logic              m_ready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // index of the requester served most recently

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant    = 2'b00;
    m_en     = 1'b0;
    m_wr     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_strb   = '0;
    p0_ready = 1'b0;
    p0_rdata = '0;
    p1_ready = 1'b0;
    p1_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (p0_en && p1_en) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (p0_en) begin
          state_d = GNT0;
        end else if (p1_en) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        grant    = 2'b01;
        m_en     = p0_en;
        m_wr     = p0_wr;
        m_addr   = p0_addr;
        m_wdata  = p0_wdata;
        m_strb   = p0_strb;
        p0_ready = m_ready;
        p0_rdata = m_rdata;
        // hand over directly so a waiting requester sees no idle gap
        if (m_ready) begin
          last_d  = 1'b0;
          state_d = p1_en ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        grant    = 2'b10;
        m_en     = p1_en;
        m_wr     = p1_wr;
        m_addr   = p1_addr;
        m_wdata  = p1_wdata;
        m_strb   = p1_strb;
        p1_ready = m_ready;
        p1_rdata = m_rdata;
        if (m_ready) begin
          last_d  = 1'b1;
          state_d = p0_en ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // an access caught by reset is abandoned: nothing reaches memory or the requester
    if (srst) begin
      grant    = 2'b00;
      m_en     = 1'b0;
      m_wr     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_strb   = '0;
      p0_ready = 1'b0;
      p0_rdata = '0;
      p1_ready = 1'b0;
      p1_rdata = '0;
    end
  end

endmodule
